// File: rtl/sigmoid_share_sched_if.sv
// Request, sigmoid and response signals of sigmoid_share_sched bundled as one
// interface; slave is the scheduler side, master the surrounding system.
interface sigmoid_share_sched_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [16*N_REQ-1:0] req_x;
    logic [N_REQ-1:0]    req_ready;
    logic [15:0]         sig_x;
    logic [15:0]         sig_fx;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_fx;
    logic                busy;

    modport slave (
        input  req_valid, req_x, sig_fx, rsp_ready,
        output req_ready, sig_x, rsp_valid, rsp_id, rsp_fx, busy
    );

    modport master (
        output req_valid, req_x, sig_fx, rsp_ready,
        input  req_ready, sig_x, rsp_valid, rsp_id, rsp_fx, busy
    );
endinterface

// File: rtl/sigmoid_share_sched.sv
// Round-robin time-sharing of one external pwla_sigmoid among N_REQ requesters;
// a tag pipeline follows each operand and results return through a credit-guarded FIFO.
module sigmoid_share_sched #(
    parameter int N_REQ       = 4,
    parameter int IDW         = 2,
    parameter int SIG_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sigmoid_share_sched_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [IDW-1:0]   rr_ptr;
    logic [N_REQ-1:0] grant_vec;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic [15:0]      grant_x;
    logic             accept;
    logic             credit;
    logic             push;
    logic             pop;
    logic             tag_any;
    logic [15:0]      sig_x_r;

    logic             tag_valid [0:SIG_LATENCY];
    logic [IDW-1:0]   tag_id    [0:SIG_LATENCY];

    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [IDW-1:0]   mem_id [0:FIFO_DEPTH-1];
    logic [15:0]      mem_fx [0:FIFO_DEPTH-1];

    always_comb begin
        inflight = '0;
        tag_any  = 1'b0;
        for (int unsigned s = 0; s <= SIG_LATENCY; s++) begin
            inflight = inflight + CW'(tag_valid[s]);
            tag_any  = tag_any | tag_valid[s];
        end
    end

    // Pops in the current cycle are deliberately ignored, so credit is conservative.
    assign credit = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);

    // Pass 0 scans rr_ptr..N_REQ-1, pass 1 wraps to 0..rr_ptr-1.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        grant_x   = '0;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!grant_any && bus.req_valid[i] && ((pass == 0) == (i >= 32'(rr_ptr)))) begin
                    grant_any    = 1'b1;
                    grant_idx    = IDW'(i);
                    grant_vec[i] = 1'b1;
                    grant_x      = bus.req_x[16*i +: 16];
                end
            end
        end
    end

    assign accept        = grant_any && credit && !reset;
    assign bus.req_ready = accept ? grant_vec : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            sig_x_r <= '0;
            for (int unsigned s = 0; s <= SIG_LATENCY; s++) begin
                tag_valid[s] <= 1'b0;
                tag_id[s]    <= '0;
            end
        end else begin
            if (accept) begin
                rr_ptr  <= (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDW'(1);
                sig_x_r <= grant_x;
            end
            tag_valid[0] <= accept;
            tag_id[0]    <= grant_idx;
            for (int unsigned s = 1; s <= SIG_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    assign push = tag_valid[SIG_LATENCY];
    assign pop  = (fifo_count != '0) && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            assert (!(push && !pop && fifo_count == CW'(FIFO_DEPTH)));
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr] <= tag_id[SIG_LATENCY];
            mem_fx[wr_ptr] <= bus.sig_fx;
        end
    end

    // Head fields read as zero while empty so stale entries never leak after a flush.
    assign bus.sig_x     = sig_x_r;
    assign bus.rsp_valid = fifo_count != '0;
    assign bus.rsp_id    = bus.rsp_valid ? mem_id[rd_ptr] : '0;
    assign bus.rsp_fx    = bus.rsp_valid ? mem_fx[rd_ptr] : '0;
    assign bus.busy      = tag_any || (fifo_count != '0);
endmodule
